// File: rtl/ysyx22040413_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx22040413_idu_stage
// Brief    : RV64I decode stage (OP-IMM, OP, LUI, AUIPC) with a registered
//            ID/EX output, valid/ready handshakes on both sides, and a
//            per-register busy scoreboard that stalls RAW/WAW hazards.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx22040413_idu_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    // IFU side
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    // register file read ports
    output logic            rs1_r_ena,
    output logic            rs2_r_ena,
    output logic [RA_W-1:0] rs1_r_addr,
    output logic [RA_W-1:0] rs2_r_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    // writeback notification
    input  logic            wb_w_ena,
    input  logic [RA_W-1:0] wb_w_addr,
    // EXU side
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_inst_type,
    output logic [7:0]      out_inst_opcode,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic            out_rd_w_ena,
    output logic [RA_W-1:0] out_rd_w_addr,
    output logic            out_illegal
);

    localparam logic [6:0] c_OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;

    localparam logic [4:0] c_TYPE_ARITH = 5'b10000;
    localparam logic [4:0] c_TYPE_LOGIC = 5'b01000;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [RA_W-1:0] w_rd;
    logic [RA_W-1:0] w_rs1;
    logic [RA_W-1:0] w_rs2;

    assign w_opcode = in_inst[6:0];
    assign w_funct3 = in_inst[14:12];
    assign w_funct7 = in_inst[31:25];
    assign w_rd     = in_inst[11:7];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];

    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_sh;
    logic [XLEN-1:0] w_imm_u;

    assign w_imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign w_imm_sh = {{(XLEN-6){1'b0}}, in_inst[25:20]};
    assign w_imm_u  = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};

    // ------------------------------------------------------------------
    // Decoded payload
    // ------------------------------------------------------------------
    logic            w_legal;
    logic [4:0]      w_type;
    logic [7:0]      w_uop;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_rd_wr;

    // Decode in_inst into micro-op, type and operands; illegal forms zero all.
    always_comb begin
        w_legal    = 1'b0;
        w_type     = 5'b0;
        w_uop      = 8'b0;
        w_op1      = '0;
        w_op2      = '0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_rd_wr    = 1'b0;

        case (w_opcode)
            c_OPC_OPIMM: begin
                w_uop[0]   = 1'b1;
                w_uop[3:1] = w_funct3;
                w_rs1_used = 1'b1;
                w_rd_wr    = 1'b1;
                w_op1      = rs1_data;
                w_op2      = w_imm_i;
                case (w_funct3)
                    3'b000, 3'b010, 3'b011: begin
                        w_legal = 1'b1;
                        w_type  = c_TYPE_ARITH;
                    end
                    3'b100, 3'b110, 3'b111: begin
                        w_legal = 1'b1;
                        w_type  = c_TYPE_LOGIC;
                    end
                    3'b001: begin
                        // slli: the 6-bit shamt leaves inst[31:26] that must be zero
                        w_legal = (in_inst[31:26] == 6'b000000);
                        w_type  = c_TYPE_LOGIC;
                        w_op2   = w_imm_sh;
                    end
                    default: begin
                        // srli / srai, selected by inst[30]
                        w_legal  = (in_inst[31:26] == 6'b000000) ||
                                   (in_inst[31:26] == 6'b010000);
                        w_type   = c_TYPE_LOGIC;
                        w_op2    = w_imm_sh;
                        w_uop[4] = in_inst[30];
                    end
                endcase
            end
            c_OPC_OP: begin
                w_uop[3:1] = w_funct3;
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_rd_wr    = 1'b1;
                w_op1      = rs1_data;
                w_op2      = rs2_data;
                if (w_funct7 == 7'b0000000) begin
                    w_legal = 1'b1;
                end else if ((w_funct7 == 7'b0100000) &&
                             ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))) begin
                    // sub / sra
                    w_legal  = 1'b1;
                    w_uop[4] = 1'b1;
                end
                if ((w_funct3 == 3'b000) || (w_funct3 == 3'b010) || (w_funct3 == 3'b011)) begin
                    w_type = c_TYPE_ARITH;
                end else begin
                    w_type = c_TYPE_LOGIC;
                end
            end
            c_OPC_LUI: begin
                w_legal    = 1'b1;
                w_type     = c_TYPE_ARITH;
                w_uop[6:5] = 2'b01;
                w_rd_wr    = 1'b1;
                w_op2      = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_legal    = 1'b1;
                w_type     = c_TYPE_ARITH;
                w_uop[6:5] = 2'b10;
                w_rd_wr    = 1'b1;
                w_op1      = in_pc;
                w_op2      = w_imm_u;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase

        if (!w_legal) begin
            w_type     = 5'b0;
            w_uop      = 8'b0;
            w_op1      = '0;
            w_op2      = '0;
            w_rs1_used = 1'b0;
            w_rs2_used = 1'b0;
            w_rd_wr    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register file reads
    // ------------------------------------------------------------------
    assign rs1_r_ena  = in_valid & w_rs1_used;
    assign rs2_r_ena  = in_valid & w_rs2_used;
    assign rs1_r_addr = rs1_r_ena ? w_rs1 : '0;
    assign rs2_r_addr = rs2_r_ena ? w_rs2 : '0;

    logic            w_rd_en;
    logic [RA_W-1:0] w_rd_addr;

    // x0 is never written, so it never occupies a scoreboard entry
    assign w_rd_en   = w_rd_wr & (w_rd != '0);
    assign w_rd_addr = w_legal ? w_rd : '0;

    // ------------------------------------------------------------------
    // Output register and scoreboard state
    // ------------------------------------------------------------------
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q;
    logic [4:0]      out_type_q;
    logic [7:0]      out_uop_q;
    logic [XLEN-1:0] out_op1_q;
    logic [XLEN-1:0] out_op2_q;
    logic            out_rd_en_q;
    logic [RA_W-1:0] out_rd_addr_q;
    logic            out_illegal_q;
    logic [NREG-1:0] busy_q, busy_d;

    // A register is pending if the scoreboard marks it or if the instruction
    // sitting in the output register is about to write it.
    function automatic logic reg_pending(input logic [RA_W-1:0] addr);
        reg_pending = busy_q[addr] | (out_valid_q & out_rd_en_q & (out_rd_addr_q == addr));
    endfunction

    logic w_src1_chk;
    logic w_src2_chk;
    logic w_dst_chk;
    logic w_hazard;
    logic w_accept;
    logic w_dispatch;

    assign w_src1_chk = rs1_r_ena & (w_rs1 != '0);
    assign w_src2_chk = rs2_r_ena & (w_rs2 != '0);
    assign w_dst_chk  = in_valid & w_rd_en;

    assign w_hazard = (w_src1_chk & reg_pending(w_rs1)) |
                      (w_src2_chk & reg_pending(w_rs2)) |
                      (w_dst_chk  & reg_pending(w_rd));

    assign in_ready   = ~flush & ~w_hazard & (~out_valid_q | out_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_dispatch = out_valid_q & out_ready & ~flush;

    // Next valid: flush kills, accept refills, dispatch without refill drains.
    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Scoreboard update: writeback clears first, dispatch set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (wb_w_ena) begin
            busy_d[wb_w_addr] = 1'b0;
        end
        if (w_dispatch && out_rd_en_q) begin
            busy_d[out_rd_addr_q] = 1'b1;
        end
    end

    // ID/EX register and scoreboard; payload loads only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_type_q    <= 5'b0;
            out_uop_q     <= 8'b0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_rd_en_q   <= 1'b0;
            out_rd_addr_q <= '0;
            out_illegal_q <= 1'b0;
            busy_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            if (w_accept) begin
                out_pc_q      <= in_pc;
                out_type_q    <= w_type;
                out_uop_q     <= w_uop;
                out_op1_q     <= w_op1;
                out_op2_q     <= w_op2;
                out_rd_en_q   <= w_rd_en;
                out_rd_addr_q <= w_rd_addr;
                out_illegal_q <= ~w_legal;
            end
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pc          = out_pc_q;
    assign out_inst_type   = out_type_q;
    assign out_inst_opcode = out_uop_q;
    assign out_op1         = out_op1_q;
    assign out_op2         = out_op2_q;
    assign out_rd_w_ena    = out_rd_en_q;
    assign out_rd_w_addr   = out_rd_addr_q;
    assign out_illegal     = out_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx22040413_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx22040413_idu_stage
// Brief    : Directed, table-driven bench for the RV64I decode stage, plus
//            hand sequences for stalls, backpressure, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx22040413_idu_stage;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            rs1_r_ena, rs2_r_ena;
    logic [RA_W-1:0] rs1_r_addr, rs2_r_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            wb_w_ena;
    logic [RA_W-1:0] wb_w_addr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_inst_type;
    logic [7:0]      out_inst_opcode;
    logic [XLEN-1:0] out_op1, out_op2;
    logic            out_rd_w_ena;
    logic [RA_W-1:0] out_rd_w_addr;
    logic            out_illegal;

    ysyx22040413_idu_stage #(.XLEN(64), .NREG(32), .RA_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .flush          (flush),
        .rs1_r_ena      (rs1_r_ena),
        .rs2_r_ena      (rs2_r_ena),
        .rs1_r_addr     (rs1_r_addr),
        .rs2_r_addr     (rs2_r_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .wb_w_ena       (wb_w_ena),
        .wb_w_addr      (wb_w_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst_type  (out_inst_type),
        .out_inst_opcode(out_inst_opcode),
        .out_op1        (out_op1),
        .out_op2        (out_op2),
        .out_rd_w_ena   (out_rd_w_ena),
        .out_rd_w_addr  (out_rd_w_addr),
        .out_illegal    (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] r1d;
        logic [63:0] r2d;
        logic [4:0]  typ;
        logic [7:0]  opc;
        logic [63:0] op1;
        logic [63:0] op2;
        logic        rde;
        logic [4:0]  rd;
        logic        ill;
        logic        r1e;
        logic [4:0]  r1a;
        logic        r2e;
        logic [4:0]  r2a;
    } vec_t;

    localparam logic [63:0] A    = 64'h1111_2222_3333_4444;
    localparam logic [63:0] B    = 64'h5555_6666_7777_8888;
    localparam logic [63:0] P    = 64'h0000_0000_0000_1000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] UHI  = 64'hFFFF_FFFF_8000_0000;
    localparam logic [4:0]  AR   = 5'b10000;
    localparam logic [4:0]  LG   = 5'b01000;
    localparam int NV = 16;

    localparam logic [31:0] I_ADDI  = 32'hFFF10093; // addi x1,x2,-1
    localparam logic [31:0] I_SRAI  = 32'h43F1D193; // srai x3,x3,63
    localparam logic [31:0] I_ADD   = 32'h00118233; // add x4,x3,x1
    localparam logic [31:0] I_ORI   = 32'h00106393; // ori x7,x0,1
    localparam logic [31:0] I_LUIX1 = 32'h800000B7; // lui x1,0x80000
    localparam logic [31:0] I_ILLRD = 32'h000000F3; // opcode 1110011, rd=1

    vec_t vecs[NV];

    initial begin
        vecs[0]  = '{I_ADDI,       P, 64'd5, B, AR, 8'h01, 64'd5, ONES,   1'b1, 5'd1,  1'b0, 1'b1, 5'd2,  1'b0, 5'd0};
        vecs[1]  = '{I_SRAI,       P, A,     B, LG, 8'h1B, A,     64'd63, 1'b1, 5'd3,  1'b0, 1'b1, 5'd3,  1'b0, 5'd0};
        vecs[2]  = '{I_ADD,        P, A,     B, AR, 8'h00, A,     B,      1'b1, 5'd4,  1'b0, 1'b1, 5'd3,  1'b1, 5'd1};
        vecs[3]  = '{32'h407302B3, P, A,     B, AR, 8'h10, A,     B,      1'b1, 5'd5,  1'b0, 1'b1, 5'd6,  1'b1, 5'd7};
        vecs[4]  = '{32'h40A4D433, P, A,     B, LG, 8'h1A, A,     B,      1'b1, 5'd8,  1'b0, 1'b1, 5'd9,  1'b1, 5'd10};
        vecs[5]  = '{32'h800002B7, P, A,     B, AR, 8'h20, 64'd0, UHI,    1'b1, 5'd5,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0};
        vecs[6]  = '{32'h80000297, 64'h8000_0000, A, B, AR, 8'h40, 64'h8000_0000, UHI, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0};
        vecs[7]  = '{32'h00F0F013, P, A,     B, LG, 8'h0F, A,     64'hF,  1'b0, 5'd0,  1'b0, 1'b1, 5'd1,  1'b0, 5'd0};
        vecs[8]  = '{32'h00511113, P, A,     B, LG, 8'h03, A,     64'd5,  1'b1, 5'd2,  1'b0, 1'b1, 5'd2,  1'b0, 5'd0};
        vecs[9]  = '{32'hFFF3B313, P, A,     B, AR, 8'h07, A,     ONES,   1'b1, 5'd6,  1'b0, 1'b1, 5'd7,  1'b0, 5'd0};
        vecs[10] = '{32'h0200D493, P, A,     B, LG, 8'h0B, A,     64'd32, 1'b1, 5'd9,  1'b0, 1'b1, 5'd1,  1'b0, 5'd0};
        vecs[11] = '{32'h00D645B3, P, A,     B, LG, 8'h08, A,     B,      1'b1, 5'd11, 1'b0, 1'b1, 5'd12, 1'b1, 5'd13};
        vecs[12] = '{32'h00000073, P, A,     B, 5'd0, 8'h00, 64'd0, 64'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0};
        vecs[13] = '{32'h023100B3, P, A,     B, 5'd0, 8'h00, 64'd0, 64'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0};
        vecs[14] = '{32'h40011113, P, A,     B, 5'd0, 8'h00, 64'd0, 64'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0};
        vecs[15] = '{32'h400030B3, P, A,     B, 5'd0, 8'h00, 64'd0, 64'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 5'd0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = '0;
        flush     = 1'b0;
        rs1_data  = '0;
        rs2_data  = '0;
        wb_w_ena  = 1'b0;
        wb_w_addr = '0;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",   out_valid, 0);
        chk("rst_out_pc",      out_pc, 0);
        chk("rst_out_type",    out_inst_type, 0);
        chk("rst_out_opcode",  out_inst_opcode, 0);
        chk("rst_out_op1",     out_op1, 0);
        chk("rst_out_op2",     out_op2, 0);
        chk("rst_out_rd_ena",  out_rd_w_ena, 0);
        chk("rst_out_rd_addr", out_rd_w_addr, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_in_ready",    in_ready, 1);
        #2 rst_n = 1'b1;
        tick();

        // ---------------- table-driven decode ----------------
        for (int i = 0; i < NV; i++) begin
            in_valid  = 1'b1;
            in_inst   = vecs[i].inst;
            in_pc     = vecs[i].pc;
            rs1_data  = vecs[i].r1d;
            rs2_data  = vecs[i].r2d;
            out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d in_ready", i),   in_ready, 1);
            chk($sformatf("v%0d rs1_r_ena", i),  rs1_r_ena, vecs[i].r1e);
            chk($sformatf("v%0d rs1_r_addr", i), rs1_r_addr, vecs[i].r1a);
            chk($sformatf("v%0d rs2_r_ena", i),  rs2_r_ena, vecs[i].r2e);
            chk($sformatf("v%0d rs2_r_addr", i), rs2_r_addr, vecs[i].r2a);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i),  out_valid, 1);
            chk($sformatf("v%0d out_pc", i),     out_pc, vecs[i].pc);
            chk($sformatf("v%0d type", i),       out_inst_type, vecs[i].typ);
            chk($sformatf("v%0d opcode", i),     out_inst_opcode, vecs[i].opc);
            chk($sformatf("v%0d op1", i),        out_op1, vecs[i].op1);
            chk($sformatf("v%0d op2", i),        out_op2, vecs[i].op2);
            chk($sformatf("v%0d rd_w_ena", i),   out_rd_w_ena, vecs[i].rde);
            chk($sformatf("v%0d rd_w_addr", i),  out_rd_w_addr, vecs[i].rd);
            chk($sformatf("v%0d illegal", i),    out_illegal, vecs[i].ill);
            tick();
            chk($sformatf("v%0d drained", i),    out_valid, 0);
            wb_w_ena  = 1'b1;
            wb_w_addr = vecs[i].rd;
            tick();
            wb_w_ena  = 1'b0;
        end

        // ---------------- RAW stall: srai x3 then add x4,x3,x1 ----------------
        in_valid  = 1'b1;
        in_inst   = I_SRAI;
        in_pc     = P;
        rs1_data  = A;
        out_ready = 1'b1;
        tick();
        chk("raw_srai_valid",  out_valid, 1);
        chk("raw_srai_opcode", out_inst_opcode, 8'h1B);
        chk("raw_srai_op2",    out_op2, 64'd63);
        in_inst = I_ADD;
        #1;
        chk("raw_vs_outreg_ready", in_ready, 0);
        tick();
        chk("raw_srai_dispatched", out_valid, 0);
        chk("raw_vs_busy_ready",   in_ready, 0);
        tick();
        chk("raw_still_stalled",   in_ready, 0);
        chk("raw_not_accepted",    out_valid, 0);
        wb_w_ena  = 1'b1;
        wb_w_addr = 5'd3;
        #1;
        chk("raw_no_bypass", in_ready, 0);
        tick();
        wb_w_ena = 1'b0;
        #1;
        chk("raw_ready_after_wb", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("raw_add_valid",  out_valid, 1);
        chk("raw_add_opcode", out_inst_opcode, 8'h00);
        chk("raw_add_rd",     out_rd_w_addr, 5'd4);
        tick();
        wb_w_ena  = 1'b1;
        wb_w_addr = 5'd4;
        tick();
        wb_w_ena  = 1'b0;

        // ---------------- backpressure then flush ----------------
        in_valid  = 1'b1;
        in_inst   = I_ADDI;
        rs1_data  = 64'd5;
        out_ready = 1'b0;
        tick();
        chk("bp_accept_valid", out_valid, 1);
        in_inst  = I_ORI;
        rs1_data = 64'd9;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d in_ready", c), in_ready, 0);
            tick();
            chk($sformatf("bp%0d out_valid", c), out_valid, 1);
            chk($sformatf("bp%0d op1", c),       out_op1, 64'd5);
            chk($sformatf("bp%0d op2", c),       out_op2, ONES);
            chk($sformatf("bp%0d rd", c),        out_rd_w_addr, 5'd1);
        end
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        in_inst   = I_ADD;
        #1;
        chk("flush_no_busy_x1", in_ready, 1);
        in_valid = 1'b0;
        tick();

        // ---------------- illegal: no stall, no scoreboard effect ----------------
        in_valid = 1'b1;
        in_inst  = I_ILLRD;
        #1;
        chk("ill_in_ready", in_ready, 1);
        chk("ill_rs1_ena",  rs1_r_ena, 0);
        tick();
        chk("ill_out_illegal", out_illegal, 1);
        chk("ill_rd_w_ena",    out_rd_w_ena, 0);
        chk("ill_type",        out_inst_type, 0);
        in_inst = I_ADD;
        #1;
        chk("ill_no_hazard", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("ill_next_valid",   out_valid, 1);
        chk("ill_next_illegal", out_illegal, 0);
        tick();
        wb_w_ena  = 1'b1;
        wb_w_addr = 5'd4;
        tick();
        wb_w_ena  = 1'b0;

        // ---------------- set wins over same-cycle clear, WAW, async reset ----------------
        in_valid = 1'b1;
        in_inst  = I_ADDI;
        tick();
        in_valid  = 1'b0;
        wb_w_ena  = 1'b1;
        wb_w_addr = 5'd1;
        tick();
        wb_w_ena = 1'b0;
        in_valid = 1'b1;
        in_inst  = I_ADD;
        #1;
        chk("set_wins_raw", in_ready, 0);
        in_inst = I_LUIX1;
        #1;
        chk("waw_stall", in_ready, 0);
        in_inst = I_ORI;
        #1;
        chk("ori_free", in_ready, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_inst   = I_ADD;
        chk("hold_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_op2",   out_op2, 0);
        chk("arst_out_rd",    out_rd_w_addr, 0);
        chk("arst_busy_cleared", in_ready, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx22040413_idu_stage.md
Name: ysyx22040413_idu_stage

Overview:
- Pipelined, parametrised RV64I decode stage with a registered ID/EX output and valid/ready handshakes on both sides.
- Decodes OP-IMM, OP, LUI and AUIPC; every other encoding is flagged illegal.
- Holds a per-register busy scoreboard and stalls on RAW/WAW hazards against issued, not-yet-written-back instructions.
- Sits between the IFU and the EXU, and reads the register file combinationally.

Parameters:
- XLEN, 64, datapath/operand width.
- NREG, 32, architectural register count; scoreboard depth.
- RA_W, 5, register address width; log2(NREG).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  IFU has an instruction.
- in_ready  out  1  stage accepts in_inst this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  redirect; kill the undispatched instruction.
- rs1_r_ena, rs2_r_ena  out  1  regfile read enables.
- rs1_r_addr, rs2_r_addr  out  RA_W  regfile read addresses.
- rs1_data, rs2_data  in  XLEN  regfile read data, same cycle.
- wb_w_ena  in  1  writeback happening.
- wb_w_addr  in  RA_W  writeback register.
- out_valid  out  1  output register holds an instruction.
- out_ready  in  1  EXU takes it.
- out_pc  out  XLEN  PC.
- out_inst_type  out  5  10000 arith, 01000 logic, 00000 illegal.
- out_inst_opcode  out  8  micro-op (see Behaviour).
- out_op1, out_op2  out  XLEN  operands.
- out_rd_w_ena  out  1  writes rd.
- out_rd_w_addr  out  RA_W  rd.
- out_illegal  out  1  unsupported encoding.

Behaviour:
- Decode (combinational on in_inst):
  - OP-IMM (0010011): addi/slti/sltiu/xori/ori/andi/slli/srli/srai.
  - OP (0110011): add/sub/sll/slt/sltu/xor/or/and/srl/sra.
  - LUI (0110111), AUIPC (0010111).
- out_inst_opcode fields:
  - bit0 = op2 is immediate.
  - bits3:1 = funct3 (0 for LUI/AUIPC).
  - bit4 = inst[30] for sub/sra/srai, else 0.
  - bits6:5 = 00 ALU, 01 LUI, 10 AUIPC.
  - bit7 = 0.
- inst_type:
  - arith for add/sub/slt/sltu, their immediate forms, LUI and AUIPC.
  - logic for and/or/xor/shifts.
- Operands:
  - op1 = rs1_data for OP/OP-IMM; 0 for LUI; in_pc for AUIPC.
  - op2 = rs2_data for OP.
  - op2 = sign-extended inst[31:20] for non-shift OP-IMM.
  - op2 = zero-extended inst[25:20] for shift-immediates.
  - op2 = sign-extended {inst[31:12],12'b0} for LUI/AUIPC.
- Illegal encodings:
  - Illegal cases: unlisted opcode or funct3; funct7 other than 0000000/0100000 where permitted; bad shamt-high bits.
  - Response: out_illegal=1, type 0, opcode 0, op1=op2=0, rd_w_ena=0, no read enables, no hazard check.
- Read enables:
  - Asserted only when in_valid and the operand is used.
  - Address is 0 when the enable is low.
- rd_w_ena=0 when rd==0; reads of x0 never hazard.
- Hazard (combinational): a used source or a writing rd matches a scoreboard busy bit, or matches out_rd_w_addr while out_valid & out_rd_w_ena.
- in_ready = ~flush & ~hazard & (~out_valid | out_ready).
- Accept (in_valid & in_ready): load the output register; out_valid=1 next cycle (latency 1).
- Hold: out_valid & ~out_ready keeps all outputs stable.
- Dispatch (out_valid & out_ready & ~flush):
  - Sets busy[out_rd_w_addr] if out_rd_w_ena.
  - out_valid clears unless a new accept occurs the same cycle.
- Writeback: wb_w_ena clears busy[wb_w_addr] at the clock edge.
  - Same-cycle set and clear of the same bit: set wins.
  - No bypass: a stalled instruction proceeds the cycle after the clear.
- flush:
  - out_valid<=0 and in_ready=0 that cycle.
  - The undispatched instruction sets no busy bit.
  - Scoreboard is untouched, so pending writebacks still clear.
- Reset (rst_n low, async): out_valid=0, every out_* register=0, scoreboard all 0. Takes effect mid-stall or mid-hold immediately.

Test Plan:
- Reset → out_valid=0, all out_* 0, in_ready=1.
- addi x1,x2,-1 (0xFFF10093), rs1_data=5, out_ready=1 → next cycle:
  - type=10000, opcode=0x01.
  - op1=5, op2=0xFFFF_FFFF_FFFF_FFFF.
  - rd=1, rd_w_ena=1.
- srai x3,x3,63 then add x4,x3,x1 back-to-back:
  - srai → opcode=0x1B, op2=63.
  - add stalls (in_ready=0) until wb_w_ena with addr 3.
  - add accepted the cycle after.
- auipc x5,0x80000 at pc=0x8000_0000 → op1=0x8000_0000, op2=0xFFFF_FFFF_8000_0000, opcode=0x40.
- Backpressure: out_ready=0 for 3 cycles → outputs stable, in_ready=0; then flush → out_valid=0 next cycle, busy[rd] stays 0.
- Illegal 0x00000073 → out_illegal=1, type=0, rd_w_ena=0, no stall, no scoreboard change.
